// File: rtl/apb_completer_pkg.sv
// Shared types and helpers for APB completers.
// State encoding, wait-counter width and byte-strobe mask.
package apb_completer_pkg;

  typedef enum logic {
    IDLE,
    ACCESS
  } state_e;

  localparam int MAX_WAIT = 15;
  localparam int CNT_W    = $clog2(MAX_WAIT + 1);
  localparam int MAX_STRB = 16;
  localparam int MAX_DW   = MAX_STRB * 8;

  // Expand byte strobes to a bit mask; callers
  // zero-extend strb and truncate the result.
  function automatic logic [MAX_DW-1:0] byte_mask(
    input logic [MAX_STRB-1:0] strb
  );
    logic [MAX_DW-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_STRB; i++)
      m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

endpackage

// File: rtl/apb_wait_cnt.sv
// Loadable down-counter with zero flag for completer wait states.
// Ports: clk, rst_n, load, load_val, dec in; cnt, zero out.
module apb_wait_cnt #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && !zero)
      cnt <= cnt - W'(1);
  end

endmodule

// File: rtl/apb_mem_completer.sv
// APB4 completer driving a single-port synchronous word memory.
// Ports: APB psel/penable/pwrite/paddr/pwdata/pstrb -> pready/prdata/
// pslverr; memory mem_wr/mem_rd/mem_be/mem_address/mem_data_in,
// mem_data_out (1-cycle read latency).
module apb_mem_completer
  import apb_completer_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int STRB_SIZE      = DATA_WIDTH / 8,
  parameter int MEM_DEPTH      = 256,
  parameter int WAIT_STATES    = 0,
  parameter int READ_STRB_MASK = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_SIZE-1:0]  pstrb,
  output logic                  pready,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pslverr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [STRB_SIZE-1:0]  mem_be,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  localparam int CW =
    (WAIT_STATES < 1) ? 1 : $clog2(WAIT_STATES + 1);
  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH + 1)'(MEM_DEPTH);
  localparam logic [STRB_SIZE-1:0] ALL_BE = '1;

  state_e                state;
  state_e                state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_SIZE-1:0]  strb_q;
  logic                  write_q;
  logic                  err_q;
  logic [CW-1:0]         cnt;
  logic                  cnt_zero;

  logic                  setup;
  logic                  in_range;
  logic                  access;
  logic                  done;
  logic                  rd_setup;
  logic                  rd_wait;
  logic                  wr_go;
  logic                  rd_ok;
  logic [DATA_WIDTH-1:0] rd_mask;

  // rst_n gates the live-input path so outputs
  // clear asynchronously with the registers.
  assign setup    = rst_n && (state == IDLE)
                    && psel && !penable;
  assign in_range = {1'b0, paddr} < DEPTH;
  assign access   = (state == ACCESS) && psel && penable;
  assign done     = access && cnt_zero;

  // Zero wait states: read in setup with the live address
  // so data is back for the single access cycle.
  assign rd_setup = setup && !pwrite && in_range
                    && (WAIT_STATES == 0);
  assign rd_wait  = access && !write_q && !err_q
                    && (WAIT_STATES > 0) && (cnt == CW'(1));
  assign wr_go    = done && write_q && !err_q
                    && (|strb_q);
  assign rd_ok    = done && !write_q && !err_q;
  assign rd_mask  =
    DATA_WIDTH'(byte_mask(MAX_STRB'(strb_q)));

  apb_wait_cnt #(
    .W (CW)
  ) u_wait_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (setup),
    .load_val (CW'(WAIT_STATES)),
    .dec      (access),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      strb_q  <= '0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (setup) begin
        addr_q  <= paddr;
        wdata_q <= pwdata;
        strb_q  <= pstrb;
        write_q <= pwrite;
        err_q   <= !in_range;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (setup) state_nxt = ACCESS;
      ACCESS: if (!psel || done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    pready      = done;
    pslverr     = done && err_q;
    mem_wr      = wr_go;
    mem_rd      = rd_setup || rd_wait;
    mem_address = '0;
    mem_be      = '0;
    mem_data_in = '0;
    prdata      = '0;
    unique case (1'b1)
      rd_setup: begin
        mem_address = paddr;
        mem_be      = ALL_BE;
      end
      rd_wait: begin
        mem_address = addr_q;
        mem_be      = ALL_BE;
      end
      wr_go: begin
        mem_address = addr_q;
        mem_be      = strb_q;
        mem_data_in = wdata_q;
      end
      default: ;
    endcase
    if (rd_ok) begin
      if ((READ_STRB_MASK != 0) && (|strb_q))
        prdata = mem_data_out & rd_mask;
      else
        prdata = mem_data_out;
    end
  end

endmodule
